// File: rtl/diode_bias_sweep_pkg.sv
// diode_sweep_pkg: shared state codes and sizing helpers for the diode bias sweep
package diode_sweep_pkg;
  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_WRITE       = 4'd1;
  localparam logic [3:0] ST_WAIT_SPI    = 4'd2;
  localparam logic [3:0] ST_SETTLE      = 4'd3;
  localparam logic [3:0] ST_PAUSE       = 4'd4;
  localparam logic [3:0] ST_CHECK       = 4'd5;
  localparam logic [3:0] ST_STEP        = 4'd6;
  localparam logic [3:0] ST_LOCK        = 4'd7;
  localparam logic [3:0] ST_LOCKWR_WAIT = 4'd8;
  localparam logic [3:0] ST_DONE        = 4'd9;
  localparam logic [3:0] ST_FAIL        = 4'd10;
  function automatic int us_to_ticks(input int us, input int clk_mhz);
    return us * clk_mhz;
  endfunction
  function automatic int timer_w(input int max_ticks);
    return (max_ticks < 2) ? 1 : $clog2(max_ticks + 1);
  endfunction
endpackage

// File: rtl/diode_bias_sweep_if.sv
// diode_bias_sweep_if: control, qualification and SPI handshake bundle of the sweep controller
interface diode_bias_sweep_if #(parameter int DAC_W = 8);
  logic             start;
  logic             abort;
  logic             noise_valid;
  logic             spi_done;
  logic [DAC_W-1:0] voltage;
  logic             spi_start;
  logic             store_en;
  logic             locked;
  logic             fail;
  logic             busy;
  modport master (
    input  start, abort, noise_valid, spi_done,
    output voltage, spi_start, store_en, locked, fail, busy
  );
  modport slave (
    output start, abort, noise_valid, spi_done,
    input  voltage, spi_start, store_en, locked, fail, busy
  );
endinterface

// File: rtl/diode_bias_sweep_timer.sv
// sweep_timer: loadable down-counter, expire flags the final cycle of the loaded count
module sweep_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else if (load) count_q <= load_val;
    else if (count_q != '0) count_q <= count_q - 1'b1;
  end
  assign expire = (count_q == '0);
endmodule

// File: rtl/diode_bias_sweep.sv
// diode_bias_sweep: ramps a DAC code until the noise detector confirms lock, then stores a backed-off code
module diode_bias_sweep
  import diode_sweep_pkg::*;
#(
  parameter int DAC_W         = 8,
  parameter int V_START       = 0,
  parameter int V_MAX         = 255,
  parameter int STEP          = 1,
  parameter int SETTLE_TICKS  = 19000,
  parameter int PAUSE_TICKS   = 250,
  parameter int CHECK_TICKS   = 5750,
  parameter int CONFIRM_N     = 4,
  parameter int BACKOFF_STEPS = 3,
  parameter int SAMPLE_MODE   = 0
) (
  input logic              clk,
  input logic              reset,
  diode_bias_sweep_if.master bus
);
  localparam int MAXT = (SETTLE_TICKS > PAUSE_TICKS) ?
                        ((SETTLE_TICKS > CHECK_TICKS) ? SETTLE_TICKS : CHECK_TICKS) :
                        ((PAUSE_TICKS > CHECK_TICKS) ? PAUSE_TICKS : CHECK_TICKS);
  localparam int TW = timer_w(MAXT);
  logic [3:0]       state_q, state_d;
  logic [DAC_W-1:0] volt_q, volt_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             lockwr_q, lockwr_d;
  logic             sticky_q, sticky_d;
  logic             load, expire, valid;
  logic [TW-1:0]    load_val;
  logic [DAC_W:0]   sum;
  logic [DAC_W+3:0] vext, back;
  assign sum   = {1'b0, volt_q} + (DAC_W+1)'(STEP);
  assign vext  = {4'b0, volt_q};
  assign back  = (DAC_W+4)'(BACKOFF_STEPS * STEP);
  assign valid = (SAMPLE_MODE != 0) ? (sticky_q & bus.noise_valid) : bus.noise_valid;
  always_comb begin
    state_d  = state_q;
    volt_d   = volt_q;
    cnt_d    = cnt_q;
    lockwr_d = lockwr_q;
    sticky_d = sticky_q;
    if (bus.abort) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      lockwr_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: if (bus.start) begin
          state_d  = ST_WRITE;
          volt_d   = DAC_W'(V_START);
          cnt_d    = '0;
          lockwr_d = 1'b0;
        end
        ST_WRITE:    state_d = ST_WAIT_SPI;
        ST_WAIT_SPI: if (bus.spi_done) state_d = lockwr_q ? ST_LOCKWR_WAIT : ST_SETTLE;
        ST_SETTLE:   if (expire) state_d = ST_PAUSE;
        ST_PAUSE: if (expire) begin
          state_d  = ST_CHECK;
          sticky_d = 1'b1;
        end
        ST_CHECK: begin
          sticky_d = sticky_q & bus.noise_valid;
          if (expire) begin
            cnt_d   = valid ? cnt_q + 1'b1 : '0;
            state_d = (valid && ({1'b0, cnt_q} + 5'd1) == 5'(CONFIRM_N)) ? ST_LOCK : ST_STEP;
          end
        end
        ST_STEP: begin
          state_d = (sum > (DAC_W+1)'(V_MAX)) ? ST_FAIL : ST_WRITE;
          volt_d  = (sum > (DAC_W+1)'(V_MAX)) ? volt_q : sum[DAC_W-1:0];
        end
        // lock write reuses WRITE/WAIT_SPI; lockwr_q steers its completion to LOCKWR_WAIT
        ST_LOCK: begin
          volt_d   = (vext >= back) ? DAC_W'(vext - back) : '0;
          lockwr_d = 1'b1;
          state_d  = ST_WRITE;
        end
        ST_LOCKWR_WAIT: state_d = ST_DONE;
        default:        state_d = ST_IDLE;
      endcase
    end
  end
  assign load     = (state_d != state_q);
  assign load_val = (state_d == ST_SETTLE) ? TW'(SETTLE_TICKS - 1) :
                    (state_d == ST_PAUSE)  ? TW'(PAUSE_TICKS - 1)  :
                    (state_d == ST_CHECK)  ? TW'(CHECK_TICKS - 1)  : '0;
  sweep_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      volt_q   <= '0;
      cnt_q    <= '0;
      lockwr_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      volt_q   <= volt_d;
      cnt_q    <= cnt_d;
      lockwr_q <= lockwr_d;
      sticky_q <= sticky_d;
    end
  end
  assign bus.voltage   = volt_q;
  assign bus.spi_start = (state_q == ST_WRITE) & ~bus.abort & ~reset;
  assign bus.store_en  = (state_q == ST_LOCKWR_WAIT) & ~bus.abort & ~reset;
  assign bus.locked    = (state_q == ST_DONE);
  assign bus.fail      = (state_q == ST_FAIL);
  assign bus.busy      = ~(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FAIL);
endmodule

// File: tb/tb_diode_bias_sweep.sv
// tb_diode_bias_sweep: drives both qualification modes side by side against a code-level sweep model
module tb_diode_bias_sweep;
  localparam int VS = 0, VM = 5, ST = 1, CN = 2, BK = 1;
  logic clk = 0, reset = 1, start = 0, abort = 0, inj = 0, glitch = 0;
  logic d01 = 0, d02 = 0, d11 = 0, d12 = 0;
  int g0 = 0, g1 = 0;
  bit tab[256];
  int checks = 0, errors = 0;
  logic [7:0] wr[2][$];
  logic [7:0] sq[2][$];
  logic [7:0] ew[2][$];
  int el[2], ev[2];
  always #5 clk = ~clk;
  diode_bias_sweep_if #(.DAC_W(8)) b0 ();
  diode_bias_sweep_if #(.DAC_W(8)) b1 ();
  assign b0.start = start;
  assign b1.start = start;
  assign b0.abort = abort;
  assign b1.abort = abort;
  assign b0.spi_done = d02 | inj;
  assign b1.spi_done = d12 | inj;
  // noise detector: per-code verdict, optionally dropped for one cycle mid check window
  assign b0.noise_valid = tab[b0.voltage] & ~(glitch && g0 == 8);
  assign b1.noise_valid = tab[b1.voltage] & ~(glitch && g1 == 8);
  always @(posedge clk) begin
    d01 <= b0.spi_start;
    d02 <= d01;
    d11 <= b1.spi_start;
    d12 <= d11;
    g0  <= b0.spi_done ? 1 : (g0 != 0 && g0 < 30) ? g0 + 1 : g0;
    g1  <= b1.spi_done ? 1 : (g1 != 0 && g1 < 30) ? g1 + 1 : g1;
  end
  always @(negedge clk) begin
    if (b0.spi_start) wr[0].push_back(b0.voltage);
    if (b1.spi_start) wr[1].push_back(b1.voltage);
    if (b0.store_en) sq[0].push_back(b0.voltage);
    if (b1.store_en) sq[1].push_back(b1.voltage);
  end
  diode_bias_sweep #(.DAC_W(8), .V_START(VS), .V_MAX(VM), .STEP(ST), .SETTLE_TICKS(4),
    .PAUSE_TICKS(2), .CHECK_TICKS(3), .CONFIRM_N(CN), .BACKOFF_STEPS(BK), .SAMPLE_MODE(0))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  diode_bias_sweep #(.DAC_W(8), .V_START(VS), .V_MAX(VM), .STEP(ST), .SETTLE_TICKS(4),
    .PAUSE_TICKS(2), .CHECK_TICKS(3), .CONFIRM_N(CN), .BACKOFF_STEPS(BK), .SAMPLE_MODE(1))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  // code-level model: walk codes, count consecutive good windows, decide lock or fail
  task automatic model(input int m);
    int c, k;
    ew[m].delete();
    c = VS;
    k = 0;
    el[m] = 0;
    while (1) begin
      ew[m].push_back(8'(c));
      k = (tab[c] && !(m == 1 && glitch)) ? k + 1 : 0;
      if (k == CN) begin
        el[m] = 1;
        ev[m] = (c - BK * ST < 0) ? 0 : c - BK * ST;
        ew[m].push_back(8'(ev[m]));
        break;
      end
      if (c + ST > VM) begin
        ev[m] = c;
        break;
      end
      c += ST;
    end
  endtask
  task automatic clear();
    wr[0].delete();
    wr[1].delete();
    sq[0].delete();
    sq[1].delete();
  endtask
  task automatic go();
    model(0);
    model(1);
    clear();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_code(input logic [7:0] code, input string tag);
    int n = 0;
    while (!(b0.spi_done && b0.voltage == code) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " reach"}, 32'(n < 600), 1);
  endtask
  task automatic finish(input string tag);
    int n = 0;
    while (!((b0.locked | b0.fail) && (b1.locked | b1.fail)) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " timeout"}, 32'(n < 600), 1);
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s m%0d locked", tag, m), 32'(m ? b1.locked : b0.locked), el[m]);
      chk($sformatf("%s m%0d fail", tag, m), 32'(m ? b1.fail : b0.fail), 1 - el[m]);
      chk($sformatf("%s m%0d voltage", tag, m), 32'(m ? b1.voltage : b0.voltage), ev[m]);
      chk($sformatf("%s m%0d stores", tag, m), sq[m].size(), el[m]);
      if (el[m] == 1 && sq[m].size() > 0)
        chk($sformatf("%s m%0d stored", tag, m), 32'(sq[m][0]), ev[m]);
      chk($sformatf("%s m%0d nwrites", tag, m), wr[m].size(), ew[m].size());
      for (int i = 0; i < ew[m].size() && i < wr[m].size(); i++)
        chk($sformatf("%s m%0d write%0d", tag, m, i), 32'(wr[m][i]), 32'(ew[m][i]));
    end
  endtask
  task automatic set_tab(input bit t0, t1, t2, t3, t4, t5);
    tab[0] = t0; tab[1] = t1; tab[2] = t2; tab[3] = t3; tab[4] = t4; tab[5] = t5;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst voltage", 32'(b0.voltage), 0);
    chk("rst busy", 32'(b0.busy), 0);
    chk("rst locked", 32'(b0.locked), 0);
    chk("rst fail", 32'(b0.fail), 0);
    chk("rst spi_start", 32'(b0.spi_start), 0);
    chk("rst store_en", 32'(b1.store_en), 0);
    reset = 0;
    @(negedge clk);
    set_tab(0, 0, 0, 0, 0, 0);
    go();
    finish("allbad");
    set_tab(0, 0, 1, 1, 1, 1);
    go();
    finish("late_valid");
    set_tab(0, 1, 0, 1, 1, 0);
    go();
    finish("reset_count");
    set_tab(1, 1, 1, 1, 1, 1);
    glitch = 1;
    go();
    finish("glitch");
    glitch = 0;
    set_tab(0, 0, 0, 0, 0, 0);
    go();
    wait_code(8'd3, "abort");
    repeat (2) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort busy", 32'(b0.busy), 0);
    chk("abort voltage", 32'(b0.voltage), 3);
    chk("abort fail", 32'(b0.fail), 0);
    chk("abort m1 busy", 32'(b1.busy), 0);
    clear();
    inj = 1;
    @(negedge clk);
    inj = 0;
    repeat (4) @(negedge clk);
    chk("late done busy", 32'(b0.busy), 0);
    chk("late done writes", wr[0].size(), 0);
    chk("late done voltage", 32'(b0.voltage), 3);
    go();
    finish("restart");
    go();
    wait_code(8'd2, "rstmid");
    repeat (8) @(negedge clk);
    chk("rstmid busy before", 32'(b0.busy), 1);
    clear();
    reset = 1;
    start = 1;
    @(negedge clk);
    chk("rstmid voltage", 32'(b0.voltage), 0);
    chk("rstmid busy", 32'(b0.busy), 0);
    chk("rstmid spi_start", 32'(b0.spi_start), 0);
    chk("rstmid store_en", 32'(b0.store_en), 0);
    chk("rstmid m1 voltage", 32'(b1.voltage), 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    start = 0;
    finish("rstmid restart");
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c <= VM; c++) tab[c] = 1'($urandom_range(0, 1));
      glitch = 1'($urandom_range(0, 1));
      go();
      finish($sformatf("rand%0d", r));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
